sub_32bit_pipe: RTL and testbench



---
 rtl/sub_32bit_pipe.sv | 184 ++++++++++++++++++
 tb/tb_sub_32bit_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_32bit_pipe.sv
// -----------------------------------------------------------------------------
// sub_32bit_pipe
//
// Pipelined subtractor: D = A - B (mod 2^WIDTH) with borrow-out B32, computed
// one WIDTH/STAGES-bit slice per register stage as A + ~B + carry.
// The whole pipeline advances together whenever the output slot is free or
// being taken.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   A/B valid this cycle
//   in_ready   block accepts A/B this cycle (= pipeline advance)
//   A, B       minuend / subtrahend, WIDTH bits
//   out_valid  D/B32 valid
//   out_ready  downstream accepts D/B32
//   D          difference, WIDTH bits
//   B32        borrow out, 1 iff A < B (unsigned)
//   V          signed overflow flag (only when SUB_OVERFLOW_EN is defined)
//
// Build option: define SUB_OVERFLOW_EN to add the V output.
// -----------------------------------------------------------------------------
module sub_32bit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             B32
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage state: operands travel with the op so later slices can use them,
  // the difference fills in one slice per stage, borrow links the slices.
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  d_r [STAGES];
  logic [STAGES-1:0] borrow_r;
  logic [STAGES-1:0] valid_r;

  // What each stage would load on an advance.
  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  d_s [STAGES];
  logic [STAGES-1:0] borrow_s;
  logic [STAGES-1:0] valid_s;

  // Per-stage source: the inputs for stage 0, the previous stage otherwise.
  logic [WIDTH-1:0]  src_a_s [STAGES];
  logic [WIDTH-1:0]  src_b_s [STAGES];
  logic [WIDTH-1:0]  src_d_s [STAGES];
  logic [STAGES-1:0] src_c_s;
  logic [STAGES-1:0] src_v_s;

  logic [SLICE:0]    sum_s;
  logic              adv_s;

  // Wire each stage to its upstream source.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign src_a_s[k] = A;
      assign src_b_s[k] = B;
      assign src_d_s[k] = '0;
      assign src_c_s[k] = 1'b1;
      assign src_v_s[k] = in_valid;
    end else begin : g_rest
      assign src_a_s[k] = a_r[k-1];
      assign src_b_s[k] = b_r[k-1];
      assign src_d_s[k] = d_r[k-1];
      // Carry into this slice is the complement of the stored borrow.
      assign src_c_s[k] = ~borrow_r[k-1];
      assign src_v_s[k] = valid_r[k-1];
    end
  end

  // Global advance and per-stage slice arithmetic.
  always_comb begin
    adv_s    = out_ready | ~valid_r[LAST];
    sum_s    = '0;
    borrow_s = '0;
    valid_s  = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
      d_s[k] = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      sum_s = {1'b0, src_a_s[k][k*SLICE +: SLICE]}
            + {1'b0, ~src_b_s[k][k*SLICE +: SLICE]}
            + {{SLICE{1'b0}}, src_c_s[k]};
      valid_s[k] = src_v_s[k];
      // Bubbles carry zeroed data so a dropped op leaves nothing behind.
      if (src_v_s[k]) begin
        a_s[k]                   = src_a_s[k];
        b_s[k]                   = src_b_s[k];
        d_s[k]                   = src_d_s[k];
        d_s[k][k*SLICE +: SLICE] = sum_s[SLICE-1:0];
        borrow_s[k]              = ~sum_s[SLICE];
      end else begin
        a_s[k]      = '0;
        b_s[k]      = '0;
        d_s[k]      = '0;
        borrow_s[k] = 1'b0;
      end
    end
  end

  // Pipeline registers: clear on reset, shift on advance, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        d_r[k] <= '0;
      end
      borrow_r <= '0;
      valid_r  <= '0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= a_s[k];
        b_r[k] <= b_s[k];
        d_r[k] <= d_s[k];
      end
      borrow_r <= borrow_s;
      valid_r  <= valid_s;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= a_r[k];
        b_r[k] <= b_r[k];
        d_r[k] <= d_r[k];
      end
      borrow_r <= borrow_r;
      valid_r  <= valid_r;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic v_s;
  logic v_r;

  // Signed overflow: operands differ in sign and the result sign differs from A.
  always_comb begin
    v_s = 1'b0;
    if (src_v_s[LAST]) begin
      v_s = (src_a_s[LAST][WIDTH-1] != src_b_s[LAST][WIDTH-1]) &
            (d_s[LAST][WIDTH-1]     != src_a_s[LAST][WIDTH-1]);
    end else begin
      v_s = 1'b0;
    end
  end

  // Overflow flag register, moves in lockstep with the final stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= 1'b0;
    end else if (adv_s) begin
      v_r <= v_s;
    end else begin
      v_r <= v_r;
    end
  end

  assign V = v_r;
`endif

  assign in_ready  = adv_s;
  assign out_valid = valid_r[LAST];
  assign D         = d_r[LAST];
  assign B32       = borrow_r[LAST];

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// -----------------------------------------------------------------------------
// tb_sub_32bit_pipe
//
// Directed and random stimulus for sub_32bit_pipe, checked against a
// queue-based reference model built from plain 33-bit / signed arithmetic.
// -----------------------------------------------------------------------------
module tb_sub_32bit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        B32;
`ifdef SUB_OVERFLOW_EN
  logic        V;
`endif

  sub_32bit_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .B32       (B32)
`ifdef SUB_OVERFLOW_EN
    ,
    .V         (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        b;
    logic [31:0] d;
  } res_t;

  res_t exp_q[$];
  int   n_vec;
  int   n_err;
  logic last_in_xfer;

  // Reference: unsigned 33-bit subtract for D/borrow, 64-bit signed for V.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    longint      sd;
    res_t        r;
    w   = {1'b0, a} - {1'b0, b};
    sd  = longint'($signed(a)) - longint'($signed(b));
    r.d = w[31:0];
    r.b = w[32];
    r.v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_D"}, 64'(D), 64'(e.d));
    check({tag, "_B32"}, 64'(B32), 64'(e.b));
`ifdef SUB_OVERFLOW_EN
    check({tag, "_V"}, 64'(V), 64'(e.v));
`endif
  endtask

  // One clock: scoreboard the handshakes about to happen, then cross the edge.
  task automatic tick();
    res_t e;
    #1;
    if (rst_n) begin
      last_in_xfer = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_res("stream", e);
        end
      end
      if (last_in_xfer) exp_q.push_back(model(A, B));
    end else begin
      last_in_xfer = 1'b0;
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Single op with out_ready=1: check latency, result, and that it leaves.
  task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd3);
    check_res(tag, model(a, b));
    tick();
    check({tag, "_gone"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          accepted;
    int          cyc;
    logic [31:0] held_d;
    logic        held_b;

    n_vec        = 0;
    n_err        = 0;
    last_in_xfer = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    A            = 32'h0;
    B            = 32'h0;

    // Reset state.
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_D", 64'(D), 64'd0);
    check("rst_B32", 64'(B32), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed values and boundaries.
    send_one("basic",   32'h0000000A, 32'h00000003);
    check("basic_const_D", 64'(model(32'h0000000A, 32'h00000003).d), 64'h7);
    send_one("zero_m1", 32'h00000000, 32'h00000001);
    send_one("equal",   32'h12345678, 32'h12345678);
    send_one("max_m0",  32'hFFFFFFFF, 32'h00000000);
    send_one("xslice",  32'h01000000, 32'h00000001);
    send_one("ovf",     32'h80000000, 32'h00000001);
    send_one("no_ovf",  32'h00000005, 32'h00000003);

    // Streaming with a three-cycle backpressure window.
    accepted = 0;
    cyc      = 0;
    held_d   = 32'h0;
    held_b   = 1'b0;
    A        = $urandom();
    B        = $urandom();
    in_valid = 1'b1;
    while (accepted < 100 && cyc < 1000) begin
      out_ready = !(cyc >= 40 && cyc < 43);
      #1;
      if (cyc == 40) begin
        held_d = D;
        held_b = B32;
        check("stall_out_valid", 64'(out_valid), 64'd1);
      end
      if (cyc >= 40 && cyc < 43) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (cyc > 40 && cyc <= 43) begin
        check("stall_hold_D", 64'(D), 64'(held_d));
        check("stall_hold_B32", 64'(B32), 64'(held_b));
      end
      tick();
      if (last_in_xfer) begin
        accepted++;
        A = $urandom();
        B = $urandom();
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", 64'(accepted), 64'd100);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("stream_no_loss", 64'(exp_q.size()), 64'd0);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      A = $urandom();
      B = $urandom();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_D", 64'(D), 64'd0);
    check("midrst_B32", 64'(B32), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    send_one("post_rst", 32'hDEADBEEF, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
